rf_wb_bypass: RTL and testbench

Write-back and operand-bypass unit for the 5-stage pipeline. It carries in-flight register writes from EX through the MEM and WB slots and drives the register file's single write port from the WB slot. On the read side it takes the ID stage's two register-file read results and substitutes newer in-flight values. It also raises the load-use stall request.

---
 rtl/rf_wb_bypass.sv | 139 +++++++++++++
 tb/tb_rf_wb_bypass.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_bypass.sv
// rf_wb_bypass
//   Write-back and operand-bypass unit for the 5-stage pipeline.
//
//   It carries in-flight register writes from EX through the MEM and WB slots,
//   and the WB slot drives the register file's single write port. On the read
//   side it replaces the ID-stage register-file read data with newer in-flight
//   values. It also raises the load-use stall request.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   hold                  freeze MEM/WB slots; suppresses the RF write
//   flush                 invalidate the EX entry as it enters MEM
//   ex_valid/we/wr/wd     EX-stage register write
//   ex_is_load            EX write data is load data, not known yet
//   mem_load_data         load data returned during the MEM cycle
//   id_rr1/2, rf_rd1/2    ID source registers and RF read data
//   id_rd1/2              bypassed operands
//   rf_we/wr/wd           RF write port
//   stall_req             load-use hazard
module rf_wb_bypass #(
  parameter int XLEN = 32,
  parameter int RA   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic            ex_we,
  input  logic [RA-1:0]   ex_wr,
  input  logic [XLEN-1:0] ex_wd,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [RA-1:0]   id_rr1,
  input  logic [RA-1:0]   id_rr2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [XLEN-1:0] id_rd1,
  output logic [XLEN-1:0] id_rd2,
  output logic            rf_we,
  output logic [RA-1:0]   rf_wr,
  output logic [XLEN-1:0] rf_wd,
  output logic            stall_req
);

  // MEM slot
  logic            r_mem_valid;
  logic            r_mem_we;
  logic [RA-1:0]   r_mem_wr;
  logic [XLEN-1:0] r_mem_wd;
  logic            r_mem_is_load;

  // WB slot (its data is already resolved, so no load flag is kept)
  logic            r_wb_valid;
  logic            r_wb_we;
  logic [RA-1:0]   r_wb_wr;
  logic [XLEN-1:0] r_wb_wd;

  logic            w_ex_writing;
  logic            w_ex_fwd;
  logic            w_mem_writing;
  logic            w_wb_writing;
  logic [XLEN-1:0] w_mem_data;

  // First match wins: x0, then EX, MEM, WB, finally the register file.
  function automatic logic [XLEN-1:0] f_bypass(
    input logic [RA-1:0]   rr,
    input logic [XLEN-1:0] rf,
    input logic            ex_en,
    input logic [RA-1:0]   ex_a,
    input logic [XLEN-1:0] ex_d,
    input logic            mem_en,
    input logic [RA-1:0]   mem_a,
    input logic [XLEN-1:0] mem_d,
    input logic            wb_en,
    input logic [RA-1:0]   wb_a,
    input logic [XLEN-1:0] wb_d
  );
    if (rr == '0)                      return '0;
    else if (ex_en  && (ex_a  == rr))  return ex_d;
    else if (mem_en && (mem_a == rr))  return mem_d;
    else if (wb_en  && (wb_a  == rr))  return wb_d;
    else                               return rf;
  endfunction

  assign w_ex_writing  = ex_valid && ex_we && (ex_wr != '0);
  // A load in EX has no data yet; it can only stall, never forward.
  assign w_ex_fwd      = w_ex_writing && !ex_is_load;
  assign w_mem_writing = r_mem_valid && r_mem_we && (r_mem_wr != '0);
  assign w_wb_writing  = r_wb_valid && r_wb_we && (r_wb_wr != '0);
  assign w_mem_data    = r_mem_is_load ? mem_load_data : r_mem_wd;

  // ---- EX -> MEM -> WB slot advance ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_valid   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_wr      <= '0;
      r_mem_wd      <= '0;
      r_mem_is_load <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_we       <= 1'b0;
      r_wb_wr       <= '0;
      r_wb_wd       <= '0;
    end else if (!hold) begin
      r_wb_valid    <= r_mem_valid;
      r_wb_we       <= r_mem_we;
      r_wb_wr       <= r_mem_wr;
      r_wb_wd       <= w_mem_data;
      r_mem_valid   <= ex_valid && !flush;
      r_mem_we      <= ex_we;
      r_mem_wr      <= ex_wr;
      r_mem_wd      <= ex_wd;
      r_mem_is_load <= ex_is_load;
    end
  end

  // ---- WB -> register file write port ----
  // Held entries write only on the cycle hold falls, so they write once.
  assign rf_we = w_wb_writing && !hold;
  assign rf_wr = r_wb_wr;
  assign rf_wd = r_wb_wd;

  // ---- ID operand bypass and load-use hazard ----
  always_comb begin
    id_rd1 = f_bypass(id_rr1, rf_rd1, w_ex_fwd, ex_wr, ex_wd,
                      w_mem_writing, r_mem_wr, w_mem_data,
                      w_wb_writing, r_wb_wr, r_wb_wd);
    id_rd2 = f_bypass(id_rr2, rf_rd2, w_ex_fwd, ex_wr, ex_wd,
                      w_mem_writing, r_mem_wr, w_mem_data,
                      w_wb_writing, r_wb_wr, r_wb_wd);
  end

  // ex_wr is nonzero whenever w_ex_writing is set, so a match implies a
  // nonzero source address. Flush is deliberately ignored here.
  assign stall_req = w_ex_writing && ex_is_load &&
                     ((ex_wr == id_rr1) || (ex_wr == id_rr2));

endmodule

// File: tb/tb_rf_wb_bypass.sv
module tb_rf_wb_bypass;
  localparam int XLEN = 32;
  localparam int RA   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            hold;
  logic            flush;
  logic            ex_valid;
  logic            ex_we;
  logic [RA-1:0]   ex_wr;
  logic [XLEN-1:0] ex_wd;
  logic            ex_is_load;
  logic [XLEN-1:0] mem_load_data;
  logic [RA-1:0]   id_rr1;
  logic [RA-1:0]   id_rr2;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] id_rd1;
  logic [XLEN-1:0] id_rd2;
  logic            rf_we;
  logic [RA-1:0]   rf_wr;
  logic [XLEN-1:0] rf_wd;
  logic            stall_req;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_bypass #(.XLEN(XLEN), .RA(RA)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_wr(ex_wr), .ex_wd(ex_wd),
    .ex_is_load(ex_is_load), .mem_load_data(mem_load_data),
    .id_rr1(id_rr1), .id_rr2(id_rr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .stall_req(stall_req)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic we, input logic [RA-1:0] wr,
                        input logic [XLEN-1:0] wd, input logic ld);
    ex_valid = v; ex_we = we; ex_wr = wr; ex_wd = wd; ex_is_load = ld;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    ex_set(1'b0, 1'b0, '0, '0, 1'b0);
    mem_load_data = '0;
    id_rr1 = '0; id_rr2 = '0; rf_rd1 = '0; rf_rd2 = '0;

    // Reset state
    #12;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_wr", {27'd0, rf_wr}, 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    #4 rst = 1'b0;
    step();
    id_rr1 = 5'd3; rf_rd1 = 32'h33; id_rr2 = 5'd0; rf_rd2 = 32'h44;
    #1;
    chk("rst_rd1_rf", id_rd1, 32'h33);
    chk("rst_rd2_x0", id_rd2, 32'h0);

    // Chain: x5 = 0x11 through EX, MEM, WB
    ex_set(1'b1, 1'b1, 5'd5, 32'h11, 1'b0);
    id_rr1 = 5'd5; rf_rd1 = 32'h99;
    #1;
    chk("chain_ex_fwd", id_rd1, 32'h11);
    step();
    ex_set(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("chain_mem_fwd", id_rd1, 32'h11);
    chk("chain_mem_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("chain_wb_we", {31'd0, rf_we}, 32'd1);
    chk("chain_wb_wr", {27'd0, rf_wr}, 32'd5);
    chk("chain_wb_wd", rf_wd, 32'h11);
    chk("chain_wb_fwd", id_rd1, 32'h11);
    step();
    chk("chain_done_we", {31'd0, rf_we}, 32'd0);
    chk("chain_rf_back", id_rd1, 32'h99);

    // Priority: WB x7=C, MEM x7=B, EX x7=A
    ex_set(1'b1, 1'b1, 5'd7, 32'hC, 1'b0);
    step();
    ex_set(1'b1, 1'b1, 5'd7, 32'hB, 1'b0);
    step();
    ex_set(1'b1, 1'b1, 5'd7, 32'hA, 1'b0);
    id_rr2 = 5'd7; rf_rd2 = 32'hD;
    #1;
    chk("prio_ex", id_rd2, 32'hA);
    ex_valid = 1'b0;
    #1;
    chk("prio_mem", id_rd2, 32'hB);
    // Rebuild with MEM on another register so only WB x7 matches
    step();
    ex_set(1'b1, 1'b1, 5'd7, 32'hC, 1'b0);
    step();
    ex_set(1'b1, 1'b1, 5'd8, 32'hB, 1'b0);
    step();
    ex_set(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("prio_wb", id_rd2, 32'hC);
    step();
    chk("prio_rf", id_rd2, 32'hD);
    step();

    // Load-use
    ex_set(1'b1, 1'b1, 5'd9, 32'hDEAD, 1'b1);
    id_rr1 = 5'd0; id_rr2 = 5'd9; mem_load_data = 32'h0;
    #1;
    chk("lu_stall_rr2", {31'd0, stall_req}, 32'd1);
    id_rr1 = 5'd9; id_rr2 = 5'd3;
    #1;
    chk("lu_stall_rr1", {31'd0, stall_req}, 32'd1);
    flush = 1'b1;
    #1;
    chk("lu_stall_flush", {31'd0, stall_req}, 32'd1);
    flush = 1'b0; id_rr1 = 5'd0; id_rr2 = 5'd9;
    step();
    ex_set(1'b0, 1'b0, '0, '0, 1'b0);
    mem_load_data = 32'h55;
    #1;
    chk("lu_mem_fwd", id_rd2, 32'h55);
    chk("lu_no_stall", {31'd0, stall_req}, 32'd0);
    step();
    mem_load_data = 32'h66;
    #1;
    chk("lu_wb_we", {31'd0, rf_we}, 32'd1);
    chk("lu_wb_wr", {27'd0, rf_wr}, 32'd9);
    chk("lu_wb_wd", rf_wd, 32'h55);
    chk("lu_wb_fwd", id_rd2, 32'h55);
    step();
    // Load to x0 never stalls
    ex_set(1'b1, 1'b1, 5'd0, 32'h0, 1'b1);
    id_rr1 = 5'd0; id_rr2 = 5'd0;
    #1;
    chk("lu_x0_nostall", {31'd0, stall_req}, 32'd0);

    // x0 write never forwards or writes
    ex_set(1'b1, 1'b1, 5'd0, 32'hFF, 1'b0);
    rf_rd1 = 32'h123;
    #1;
    chk("x0_ex_rd1", id_rd1, 32'h0);
    step();
    ex_set(1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("x0_mem_we", {31'd0, rf_we}, 32'd0);
    step();
    chk("x0_wb_we", {31'd0, rf_we}, 32'd0);

    // Flushed EX write to x4 is dropped
    ex_set(1'b1, 1'b1, 5'd4, 32'h44, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    ex_set(1'b0, 1'b0, '0, '0, 1'b0);
    id_rr1 = 5'd4; rf_rd1 = 32'h40;
    #1;
    chk("flush_mem_rd1", id_rd1, 32'h40);
    step();
    chk("flush_wb_we", {31'd0, rf_we}, 32'd0);
    chk("flush_wb_rd1", id_rd1, 32'h40);
    step();

    // Hold: WB x6=0x77, MEM x11=0xBB, hold for 3 cycles
    ex_set(1'b1, 1'b1, 5'd6, 32'h77, 1'b0);
    step();
    ex_set(1'b1, 1'b1, 5'd11, 32'hBB, 1'b0);
    step();
    ex_set(1'b0, 1'b0, '0, '0, 1'b0);
    hold = 1'b1;
    id_rr1 = 5'd11; rf_rd1 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold_we_%0d", i), {31'd0, rf_we}, 32'd0);
      chk($sformatf("hold_wr_%0d", i), {27'd0, rf_wr}, 32'd6);
      chk($sformatf("hold_mem_%0d", i), id_rd1, 32'hBB);
      step();
    end
    hold = 1'b0;
    #1;
    chk("hold_rel_we", {31'd0, rf_we}, 32'd1);
    chk("hold_rel_wr", {27'd0, rf_wr}, 32'd6);
    chk("hold_rel_wd", rf_wd, 32'h77);
    step();
    chk("hold_next_wr", {27'd0, rf_wr}, 32'd11);
    chk("hold_next_wd", rf_wd, 32'hBB);
    step();
    chk("hold_done_we", {31'd0, rf_we}, 32'd0);

    // Asynchronous reset with both slots valid
    ex_set(1'b1, 1'b1, 5'd12, 32'hC12, 1'b0);
    step();
    ex_set(1'b1, 1'b1, 5'd13, 32'hC13, 1'b0);
    step();
    ex_set(1'b0, 1'b0, '0, '0, 1'b0);
    id_rr1 = 5'd13; rf_rd1 = 32'h3;
    #1;
    chk("arst_pre_we", {31'd0, rf_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_we", {31'd0, rf_we}, 32'd0);
    chk("arst_wr", {27'd0, rf_wr}, 32'd0);
    chk("arst_rd1", id_rd1, 32'h3);
    step();
    rst = 1'b0;
    id_rr1 = 5'd3; rf_rd1 = 32'h33;
    #1;
    chk("arst_rel_rd1", id_rd1, 32'h33);
    step();
    chk("arst_rel_we", {31'd0, rf_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
